// File: rtl/qpll_reset_sequencer.sv
// qpll_reset_sequencer
// Multi-QPLL reset sequencer. It waits out the post-configuration settling
// time, then runs one FSM per QPLL. Each FSM pulses that QPLL's reset, waits
// for a stable lock, and re-resets on lock loss, on lock timeout (bounded
// retries) or on a channel request.
//
// Ports
//   STABLE_CLOCK    in   1         free-running board clock
//   SOFT_RESET_N    in   1         synchronous active-low reset
//   QPLL_LOCK       in   NUM_QPLL  QPLL lock (asynchronous, synchronized here)
//   CHAN_RESET_REQ  in   NUM_QPLL  per-QPLL re-reset request, 1-cycle pulse
//   COMMON_RESET    out  NUM_QPLL  per-QPLL reset
//   PLL_READY       out  NUM_QPLL  QPLL locked and stable
//   ALL_READY       out  1         registered AND of PLL_READY
//   FAIL            out  NUM_QPLL  retry budget exhausted
//
// state      | meaning
// -----------+------------------------------------------------------------
// INIT       | outputs low, waiting for startup_done
// ASSERT     | COMMON_RESET high, pulse down-counter running
// WAIT_LOCK  | waiting for a run of synced lock, timeout down-counter running
// READY      | PLL_READY high, watching for lock loss
// FAILED     | FAIL high, held until soft reset or channel request
module qpll_reset_sequencer #(
    parameter int STABLE_CLOCK_PERIOD = 8,
    parameter int NUM_QPLL            = 2,
    parameter int STARTUP_DELAY_NS    = 500,
    parameter int RESET_PULSE_CYCLES  = 4,
    parameter int LOCK_STABLE_CYCLES  = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 1000,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                STABLE_CLOCK,
    input  logic                SOFT_RESET_N,
    input  logic [NUM_QPLL-1:0] QPLL_LOCK,
    input  logic [NUM_QPLL-1:0] CHAN_RESET_REQ,
    output logic [NUM_QPLL-1:0] COMMON_RESET,
    output logic [NUM_QPLL-1:0] PLL_READY,
    output logic                ALL_READY,
    output logic [NUM_QPLL-1:0] FAIL
);

    localparam int WAIT_MAX  = STARTUP_DELAY_NS / STABLE_CLOCK_PERIOD + 10;
    localparam int STARTUP_W = $clog2(WAIT_MAX + 1);
    localparam int PULSE_W   = $clog2(RESET_PULSE_CYCLES + 1);
    localparam int STABLE_W  = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int TMO_W     = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int RETRY_W   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_ASSERT    = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_READY     = 3'd3,
        ST_FAILED    = 3'd4
    } state_t;

    // The startup wait is measured from configuration, so these two flops
    // take their value from the bitstream and ignore SOFT_RESET_N.
    logic [STARTUP_W-1:0] startup_cnt  = '0;
    logic                 startup_done = 1'b0;

    always_ff @(posedge STABLE_CLOCK) begin
        if (startup_cnt != STARTUP_W'(WAIT_MAX)) begin
            startup_cnt <= startup_cnt + 1'b1;
        end
        startup_done <= (startup_cnt == STARTUP_W'(WAIT_MAX));
    end

    // Plain 2-flop synchronizer; it keeps sampling through soft reset.
    logic [NUM_QPLL-1:0] lock_meta;
    logic [NUM_QPLL-1:0] lock_sync;

    always_ff @(posedge STABLE_CLOCK) begin
        lock_meta <= QPLL_LOCK;
        lock_sync <= lock_meta;
    end

    genvar g;
    generate
        for (g = 0; g < NUM_QPLL; g++) begin : g_qpll
            state_t              state_q = ST_INIT;
            state_t              state_d;
            logic [PULSE_W-1:0]  pulse_q, pulse_d;
            logic [TMO_W-1:0]    tmo_q, tmo_d;
            logic [STABLE_W-1:0] stable_q, stable_d;
            logic [RETRY_W-1:0]  retry_q, retry_d;
            logic                req_ok;

            always_ff @(posedge STABLE_CLOCK) begin
                if (!SOFT_RESET_N) begin
                    state_q  <= ST_INIT;
                    pulse_q  <= '0;
                    tmo_q    <= '0;
                    stable_q <= '0;
                    retry_q  <= '0;
                end else begin
                    state_q  <= state_d;
                    pulse_q  <= pulse_d;
                    tmo_q    <= tmo_d;
                    stable_q <= stable_d;
                    retry_q  <= retry_d;
                end
            end

            always_comb begin
                state_d  = state_q;
                pulse_d  = pulse_q;
                tmo_d    = tmo_q;
                stable_d = stable_q;
                retry_d  = retry_q;
                req_ok   = (state_q == ST_ASSERT) || (state_q == ST_WAIT_LOCK) ||
                           (state_q == ST_READY)  || (state_q == ST_FAILED);

                case (state_q)
                    ST_INIT: begin
                        if (startup_done) begin
                            state_d = ST_ASSERT;
                            pulse_d = PULSE_W'(RESET_PULSE_CYCLES - 1);
                            retry_d = '0;
                        end
                    end
                    ST_ASSERT: begin
                        if (pulse_q == '0) begin
                            state_d  = ST_WAIT_LOCK;
                            tmo_d    = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
                            stable_d = '0;
                        end else begin
                            pulse_d = pulse_q - 1'b1;
                        end
                    end
                    ST_WAIT_LOCK: begin
                        stable_d = lock_sync[g] ? stable_q + 1'b1 : '0;
                        // Lock run completing wins over a timeout on the same edge.
                        if (lock_sync[g] && stable_q == STABLE_W'(LOCK_STABLE_CYCLES - 1)) begin
                            state_d = ST_READY;
                        end else if (tmo_q == '0) begin
                            if (retry_q < RETRY_W'(MAX_RETRIES)) begin
                                retry_d = retry_q + 1'b1;
                                state_d = ST_ASSERT;
                                pulse_d = PULSE_W'(RESET_PULSE_CYCLES - 1);
                            end else begin
                                state_d = ST_FAILED;
                            end
                        end else begin
                            tmo_d = tmo_q - 1'b1;
                        end
                    end
                    ST_READY: begin
                        if (!lock_sync[g]) begin
                            state_d = ST_ASSERT;
                            pulse_d = PULSE_W'(RESET_PULSE_CYCLES - 1);
                            retry_d = '0;
                        end
                    end
                    ST_FAILED: begin
                        state_d = ST_FAILED;
                    end
                    default: begin
                        state_d = ST_INIT;
                    end
                endcase

                // A channel request overrides whatever the FSM decided above,
                // and reloading the pulse counter stretches an active pulse.
                if (CHAN_RESET_REQ[g] && req_ok) begin
                    state_d = ST_ASSERT;
                    pulse_d = PULSE_W'(RESET_PULSE_CYCLES - 1);
                    retry_d = '0;
                end
            end

            assign COMMON_RESET[g] = (state_q == ST_ASSERT);
            assign PLL_READY[g]    = (state_q == ST_READY);
            assign FAIL[g]         = (state_q == ST_FAILED);
        end
    endgenerate

    logic all_ready_q = 1'b0;

    always_ff @(posedge STABLE_CLOCK) begin
        if (!SOFT_RESET_N) begin
            all_ready_q <= 1'b0;
        end else begin
            all_ready_q <= &PLL_READY;
        end
    end

    assign ALL_READY = all_ready_q;

endmodule

// File: tb/tb_qpll_reset_sequencer.sv
module tb_qpll_reset_sequencer;

    localparam int WAIT_MAX     = 500 / 8 + 10;
    localparam int PULSE        = 4;
    localparam int LOCK_STABLE  = 16;
    localparam int LOCK_TIMEOUT = 1000;
    localparam int MAX_RETRIES  = 3;

    logic       clk = 1'b0;
    logic       soft_reset_n = 1'b1;
    logic [1:0] qpll_lock = 2'b00;
    logic [1:0] chan_reset_req = 2'b00;
    logic [1:0] common_reset;
    logic [1:0] pll_ready;
    logic       all_ready;
    logic [1:0] fail_flags;

    int tests = 0;
    int fails = 0;

    qpll_reset_sequencer dut (
        .STABLE_CLOCK   (clk),
        .SOFT_RESET_N   (soft_reset_n),
        .QPLL_LOCK      (qpll_lock),
        .CHAN_RESET_REQ (chan_reset_req),
        .COMMON_RESET   (common_reset),
        .PLL_READY      (pll_ready),
        .ALL_READY      (all_ready),
        .FAIL           (fail_flags)
    );

    always #4 clk = ~clk;

    // Behavioural model: each QPLL is described by how many reset cycles
    // remain, how long it has been waiting, its current lock run, and flags.
    int         edge_cnt = 0;
    logic [1:0] samp [0:8191];
    int         m_left  [2];
    bit         m_wait  [2];
    int         m_wcyc  [2];
    int         m_run   [2];
    bit         m_ready [2];
    bit         m_fail  [2];
    int         m_retry [2];
    bit         m_active[2];
    bit         m_all = 1'b0;

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_left[i] = 0; m_wait[i] = 0; m_wcyc[i] = 0; m_run[i] = 0;
            m_ready[i] = 0; m_fail[i] = 0; m_retry[i] = 0; m_active[i] = 0;
        end
    end

    task automatic start_pulse(input int i);
        m_left[i]  = PULSE;
        m_wait[i]  = 0;
        m_ready[i] = 0;
        m_fail[i]  = 0;
    endtask

    always @(posedge clk) begin
        logic [1:0] synced;
        bit         start_ok;
        edge_cnt = edge_cnt + 1;
        samp[edge_cnt] = qpll_lock;
        synced   = (edge_cnt >= 3) ? samp[edge_cnt-2] : 2'b00;
        start_ok = (edge_cnt >= WAIT_MAX + 2);
        m_all    = soft_reset_n ? (m_ready[0] & m_ready[1]) : 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (!soft_reset_n) begin
                m_left[i] = 0; m_wait[i] = 0; m_ready[i] = 0;
                m_fail[i] = 0; m_active[i] = 0; m_retry[i] = 0;
            end else if (m_active[i] && chan_reset_req[i]) begin
                start_pulse(i);
                m_retry[i] = 0;
            end else if (!m_active[i]) begin
                if (start_ok) begin
                    m_active[i] = 1;
                    start_pulse(i);
                    m_retry[i] = 0;
                end
            end else if (m_left[i] > 0) begin
                m_left[i] = m_left[i] - 1;
                if (m_left[i] == 0) begin
                    m_wait[i] = 1; m_wcyc[i] = 0; m_run[i] = 0;
                end
            end else if (m_wait[i]) begin
                m_wcyc[i] = m_wcyc[i] + 1;
                m_run[i]  = synced[i] ? m_run[i] + 1 : 0;
                if (m_run[i] == LOCK_STABLE) begin
                    m_wait[i] = 0; m_ready[i] = 1;
                end else if (m_wcyc[i] == LOCK_TIMEOUT) begin
                    m_wait[i] = 0;
                    if (m_retry[i] < MAX_RETRIES) begin
                        m_retry[i] = m_retry[i] + 1;
                        start_pulse(i);
                    end else begin
                        m_fail[i] = 1;
                    end
                end
            end else if (m_ready[i]) begin
                if (!synced[i]) begin
                    m_ready[i] = 0; m_retry[i] = 0;
                    start_pulse(i);
                end
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        logic [6:0] exp_v;
        logic [6:0] got_v;
        if (edge_cnt > 0) begin
            exp_v = {m_left[1] > 0, m_left[0] > 0, m_ready[1], m_ready[0], m_all, m_fail[1], m_fail[0]};
            got_v = {common_reset, pll_ready, all_ready, fail_flags};
            tests = tests + 1;
            if (got_v !== exp_v) begin
                fails = fails + 1;
                $display("FAIL model_cmp edge %0d: got cr=%b rdy=%b all=%b fail=%b, expected cr=%b rdy=%b all=%b fail=%b",
                         edge_cnt, got_v[6:5], got_v[4:3], got_v[2], got_v[1:0],
                         exp_v[6:5], exp_v[4:3], exp_v[2], exp_v[1:0]);
            end
        end
    end

    task automatic at(input int n);
        while (edge_cnt < n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [1:0] got, input logic [1:0] exp);
        tests = tests + 1;
        if (got !== exp) begin
            fails = fails + 1;
            $display("FAIL %s edge %0d: got %b, expected %b", nm, edge_cnt, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete at edge %0d", edge_cnt);
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        at(1);    chk("cfg_outputs", {common_reset | pll_ready | fail_flags}, 2'b00);
        at(73);   chk("startup_wait_cr", common_reset, 2'b00);
        at(74);   chk("startup_rise_cr", common_reset, 2'b11);
                  chk("startup_rdy", pll_ready, 2'b00);
        at(77);   chk("pulse_last_cr", common_reset, 2'b11);
        at(78);   chk("pulse_fall_cr", common_reset, 2'b00);
        at(79);   qpll_lock[0] = 1'b1;
        at(96);   chk("lock0_not_yet", {1'b0, pll_ready[0]}, 2'b00);
        at(97);   chk("lock0_ready", {1'b0, pll_ready[0]}, 2'b01);
                  chk("all_ready_one_only", {1'b0, all_ready}, 2'b00);

        at(499);  qpll_lock[0] = 1'b0;
        at(500);  qpll_lock[0] = 1'b1;
        at(501);  chk("loss_still_ready", {1'b0, pll_ready[0]}, 2'b01);
        at(502);  chk("loss_rdy_drop", {1'b0, pll_ready[0]}, 2'b00);
                  chk("loss_pulse_rise", {1'b0, common_reset[0]}, 2'b01);
        at(505);  chk("loss_pulse_hold", {1'b0, common_reset[0]}, 2'b01);
        at(506);  chk("loss_pulse_fall", {1'b0, common_reset[0]}, 2'b00);
        at(521);  chk("relock_not_yet", {1'b0, pll_ready[0]}, 2'b00);
        at(522);  chk("relock_ready", {1'b0, pll_ready[0]}, 2'b01);
                  chk("loss_no_fail", fail_flags, 2'b00);

        at(1077); chk("retry1_before", {1'b0, common_reset[1]}, 2'b00);
        at(1078); chk("retry1_pulse", {1'b0, common_reset[1]}, 2'b01);
        at(2082); chk("retry2_pulse", {1'b0, common_reset[1]}, 2'b01);
        at(3086); chk("retry3_pulse", {1'b0, common_reset[1]}, 2'b01);
        at(4089); chk("fail_before", fail_flags, 2'b00);
        at(4090); chk("fail_after_4th", fail_flags, 2'b10);
                  chk("qpll0_unaffected", {1'b0, pll_ready[0]}, 2'b01);

        at(4099); qpll_lock[1] = 1'b1;
        at(4109); chan_reset_req[1] = 1'b1;
        at(4110); chan_reset_req[1] = 1'b0;
                  chk("req_clears_fail", fail_flags, 2'b00);
                  chk("req_pulse", {1'b0, common_reset[1]}, 2'b01);
        at(4111); chan_reset_req[1] = 1'b1;
        at(4112); chan_reset_req[1] = 1'b0;
        at(4115); chk("req_extend_hold", {1'b0, common_reset[1]}, 2'b01);
        at(4116); chk("req_extend_fall", {1'b0, common_reset[1]}, 2'b00);
        at(4132); chk("lock1_ready", pll_ready, 2'b11);
                  chk("all_ready_lag", {1'b0, all_ready}, 2'b00);
        at(4133); chk("all_ready_set", {1'b0, all_ready}, 2'b01);

        at(4199); chan_reset_req[0] = 1'b1;
        at(4200); chan_reset_req[0] = 1'b0;
                  chk("req0_pulse", common_reset, 2'b01);
                  chk("all_ready_held", {1'b0, all_ready}, 2'b01);
        at(4201); chk("all_ready_drop", {1'b0, all_ready}, 2'b00);
        at(4209); soft_reset_n = 1'b0;
        at(4210); chk("rst_cr", common_reset, 2'b00);
                  chk("rst_rdy", pll_ready, 2'b00);
                  chk("rst_all", {1'b0, all_ready}, 2'b00);
                  chk("rst_fail", fail_flags, 2'b00);
        at(4211); soft_reset_n = 1'b1;
        at(4212); chk("release_pulse", common_reset, 2'b11);
        at(4216); chk("release_fall", common_reset, 2'b00);
        at(4232); chk("release_ready", pll_ready, 2'b11);
        at(4233); chk("release_all", {1'b0, all_ready}, 2'b01);
        at(4240);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
